// File: rtl/sdram_pkg.sv
// Shared SDRAM host-side widths, arbiter state encoding and request payload.
package sdram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BSEL_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // One latched host request as presented to the controller.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic [BSEL_W-1:0] bytesel;
  } host_req_t;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester above i_last, wrapping.
module rr_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  int unsigned    w_ofs;

  // Rotate requests so bit 0 is the port just after the last winner.
  assign w_dbl = {i_req, i_req};
  assign w_rot = N'(w_dbl >> (32'(i_last) + 32'd1));

  // Lowest set bit of the rotated vector is the winner's offset.
  always_comb begin
    w_ofs = 0;
    o_any = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!o_any && w_rot[j]) begin
        o_any = 1'b1;
        w_ofs = j;
      end
    end
  end

  assign o_idx   = IDX_W'((32'(i_last) + 32'd1 + w_ofs) % N);
  assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller host port among NUM_PORTS requesters.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned TO_W      = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  input  logic [NUM_PORTS-1:0]        p_wr_en,
  input  logic [NUM_PORTS*BSEL_W-1:0] p_bytesel,
  output logic [DATA_W-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]        p_compl,
  output logic [NUM_PORTS-1:0]        p_err,
  output logic [NUM_PORTS-1:0]        p_grant,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_wdata,
  output logic                        m_wr_en,
  output logic [BSEL_W-1:0]           m_bytesel,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic                        m_compl,
  input  logic                        m_config_done
);

  localparam int unsigned LIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  host_req_t           r_req;
  host_req_t           w_req_sel;
  logic [NUM_PORTS-1:0] r_grant;
  logic [LIDX_W-1:0]   r_owner;
  logic [LIDX_W-1:0]   r_last;
  logic [TO_W-1:0]     r_wd;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_pick;
  logic [LIDX_W-1:0]   w_pick_idx;
  logic                w_any;
  logic                w_load;
  logic                w_release;

  // A port is requesting whenever any of its byte enables is set.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_req
    assign w_req[g] = |p_bytesel[g*BSEL_W +: BSEL_W];
  end

  rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (LIDX_W)
  ) u_picker (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  // Select the winning port's request fields.
  always_comb begin
    w_req_sel = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_pick[i]) begin
        w_req_sel.addr    = p_addr[i*ADDR_W +: ADDR_W];
        w_req_sel.wdata   = p_wdata[i*DATA_W +: DATA_W];
        w_req_sel.wr_en   = p_wr_en[i];
        w_req_sel.bytesel = p_bytesel[i*BSEL_W +: BSEL_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus same-cycle completion / error routing; completion beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_release   = 1'b0;
    p_compl     = '0;
    p_err       = '0;
    case (r_state)
      ST_IDLE: begin
        if (m_config_done && w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_compl) begin
          p_compl     = r_grant;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wd == TO_W'(TIMEOUT - 1)) begin
          p_err       = r_grant;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched request, ownership, round-robin pointer and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= LIDX_W'(NUM_PORTS - 1);
      r_wd    <= '0;
    end else if (w_load) begin
      r_req   <= w_req_sel;
      r_grant <= w_pick;
      r_owner <= w_pick_idx;
      r_wd    <= '0;
    end else if (w_release) begin
      r_req.bytesel <= '0;
      r_req.wr_en   <= 1'b0;
      r_grant       <= '0;
      r_last        <= r_owner;
    end else if (r_state == ST_BUSY) begin
      r_wd <= r_wd + TO_W'(1);
    end
  end

  assign m_addr    = r_req.addr;
  assign m_wdata   = r_req.wdata;
  assign m_wr_en   = r_req.wr_en;
  assign m_bytesel = r_req.bytesel;
  assign p_grant   = r_grant;
  assign p_rdata   = m_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter (2 ports, TIMEOUT 64).
module tb_sdram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [63:0] p_addr;
  logic [31:0] p_wdata;
  logic [1:0]  p_wr_en;
  logic [3:0]  p_bytesel;
  logic [15:0] p_rdata;
  logic [1:0]  p_compl;
  logic [1:0]  p_err;
  logic [1:0]  p_grant;
  logic [31:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;
  logic [15:0] m_rdata;
  logic        m_compl;
  logic        m_config_done;

  int          n_cmp;
  int          n_mis;
  logic [1:0]  exp_g;
  logic [31:0] exp_a;

  sdram_arbiter #(
    .NUM_PORTS (2),
    .TIMEOUT   (64),
    .TO_W      (7)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .p_addr        (p_addr),
    .p_wdata       (p_wdata),
    .p_wr_en       (p_wr_en),
    .p_bytesel     (p_bytesel),
    .p_rdata       (p_rdata),
    .p_compl       (p_compl),
    .p_err         (p_err),
    .p_grant       (p_grant),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_wr_en       (m_wr_en),
    .m_bytesel     (m_bytesel),
    .m_rdata       (m_rdata),
    .m_compl       (m_compl),
    .m_config_done (m_config_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    p_addr = '0;
    p_wdata = '0;
    p_wr_en = '0;
    p_bytesel = '0;
    m_rdata = '0;
    m_compl = 1'b0;
    m_config_done = 1'b0;

    // Reset values
    repeat (2) cyc();
    check_eq("rst_bytesel", 64'(m_bytesel), 64'd0);
    check_eq("rst_wr_en", 64'(m_wr_en), 64'd0);
    check_eq("rst_addr", 64'(m_addr), 64'd0);
    check_eq("rst_grant", 64'(p_grant), 64'd0);
    check_eq("rst_compl", 64'(p_compl), 64'd0);
    check_eq("rst_err", 64'(p_err), 64'd0);
    rst_n = 1'b1;

    // 1. Config gate
    p_addr[31:0] = 32'h0000_1000;
    p_bytesel[1:0] = 2'b11;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_eq("cfg_gate_bsel", 64'(m_bytesel), 64'd0);
    end
    m_config_done = 1'b1;
    cyc();
    check_eq("cfg_bsel", 64'(m_bytesel), 64'h3);
    check_eq("cfg_addr", 64'(m_addr), 64'h1000);
    check_eq("cfg_grant", 64'(p_grant), 64'h1);
    check_eq("cfg_wr_en", 64'(m_wr_en), 64'd0);
    cyc();
    m_compl = 1'b1;
    m_rdata = 16'h5555;
    p_bytesel[1:0] = 2'b00;
    #1;
    check_eq("cfg_compl", 64'(p_compl), 64'h1);
    check_eq("cfg_rdata", 64'(p_rdata), 64'h5555);
    cyc();
    m_compl = 1'b0;
    check_eq("cfg_rel_bsel", 64'(m_bytesel), 64'd0);
    check_eq("cfg_rel_grant", 64'(p_grant), 64'd0);

    // 2. Single read from port 1
    p_addr[63:32] = 32'h0080_0002;
    p_bytesel[3:2] = 2'b01;
    cyc();
    check_eq("rd_grant", 64'(p_grant), 64'h2);
    check_eq("rd_bsel", 64'(m_bytesel), 64'h1);
    check_eq("rd_addr", 64'(m_addr), 64'h0080_0002);
    repeat (5) cyc();
    check_eq("rd_wait_compl", 64'(p_compl), 64'd0);
    m_compl = 1'b1;
    m_rdata = 16'hA5C3;
    p_bytesel[3:2] = 2'b00;
    #1;
    check_eq("rd_compl", 64'(p_compl), 64'h2);
    check_eq("rd_rdata", 64'(p_rdata), 64'hA5C3);
    check_eq("rd_err", 64'(p_err), 64'd0);
    cyc();
    m_compl = 1'b0;
    m_rdata = '0;
    check_eq("rd_rel_bsel", 64'(m_bytesel), 64'd0);

    // 3. Round-robin fairness with both ports requesting continuously
    p_addr = {32'h0000_0200, 32'h0000_0100};
    p_bytesel = 4'b1011;
    for (int k = 0; k < 8; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 32'h100 : 32'h200;
      cyc();
      check_eq("rr_grant", 64'(p_grant), 64'(exp_g));
      check_eq("rr_addr", 64'(m_addr), 64'(exp_a));
      cyc();
      m_compl = 1'b1;
      #1;
      check_eq("rr_compl", 64'(p_compl), 64'(exp_g));
      cyc();
      m_compl = 1'b0;
      #1;
      check_eq("rr_idle_grant", 64'(p_grant), 64'd0);
      check_eq("rr_idle_bsel", 64'(m_bytesel), 64'd0);
    end

    // 5a. Timeout on port 0, then port 1 is served
    p_addr = {32'h0000_0500, 32'h0000_0400};
    p_bytesel = 4'b1111;
    cyc();
    check_eq("to_grant", 64'(p_grant), 64'h1);
    for (int k = 0; k < 63; k++) begin
      check_eq("to_early_err", 64'(p_err), 64'd0);
      cyc();
    end
    check_eq("to_err", 64'(p_err), 64'h1);
    check_eq("to_no_compl", 64'(p_compl), 64'd0);
    p_bytesel[1:0] = 2'b00;
    cyc();
    check_eq("to_idle_grant", 64'(p_grant), 64'd0);
    check_eq("to_idle_bsel", 64'(m_bytesel), 64'd0);
    check_eq("to_err_gone", 64'(p_err), 64'd0);
    cyc();
    check_eq("to_next_grant", 64'(p_grant), 64'h2);
    check_eq("to_next_addr", 64'(m_addr), 64'h500);

    // 5b. Completion on the timeout cycle wins
    repeat (63) cyc();
    m_compl = 1'b1;
    #1;
    check_eq("co_compl", 64'(p_compl), 64'h2);
    check_eq("co_no_err", 64'(p_err), 64'd0);
    p_bytesel = '0;
    cyc();
    m_compl = 1'b0;
    check_eq("co_idle_grant", 64'(p_grant), 64'd0);

    // 4. Write isolation
    p_addr[31:0] = 32'h0000_0300;
    p_wdata[15:0] = 16'h1234;
    p_wr_en = 2'b01;
    p_bytesel = 4'b0011;
    check_eq("wr_idle_wr_en", 64'(m_wr_en), 64'd0);
    cyc();
    check_eq("wr_grant", 64'(p_grant), 64'h1);
    check_eq("wr_wr_en", 64'(m_wr_en), 64'h1);
    check_eq("wr_wdata", 64'(m_wdata), 64'h1234);
    p_wdata[15:0] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("wr_hold_wdata", 64'(m_wdata), 64'h1234);
      check_eq("wr_hold_wr_en", 64'(m_wr_en), 64'h1);
    end
    m_compl = 1'b1;
    p_bytesel = '0;
    #1;
    check_eq("wr_compl", 64'(p_compl), 64'h1);
    cyc();
    m_compl = 1'b0;
    p_wr_en = '0;
    check_eq("wr_idle1_wr_en", 64'(m_wr_en), 64'd0);
    cyc();
    check_eq("wr_idle2_wr_en", 64'(m_wr_en), 64'd0);

    // 6. Reset mid-access, stray completion, port 0 first afterwards
    p_addr = {32'h0000_0700, 32'h0000_0600};
    p_bytesel = 4'b0011;
    cyc();
    check_eq("rs_grant", 64'(p_grant), 64'h1);
    cyc();
    rst_n = 1'b0;
    #1;
    check_eq("rs_bsel", 64'(m_bytesel), 64'd0);
    check_eq("rs_grant_clr", 64'(p_grant), 64'd0);
    p_bytesel = 4'b1111;
    cyc();
    rst_n = 1'b1;
    m_compl = 1'b1;
    #1;
    check_eq("rs_stray_compl", 64'(p_compl), 64'd0);
    cyc();
    m_compl = 1'b0;
    check_eq("rs_first_grant", 64'(p_grant), 64'h1);
    check_eq("rs_first_addr", 64'(m_addr), 64'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
